ra_march_sdr: RTL
=================

RA_MARCH_SDR -- requirements
Module: ra_march_sdr

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning array read latency in cycles from rd enb/adr to rd_dat valid (legal range 1..3).
REQ-002 SHALL have parameter FAIL_CW, default 8, meaning width of the saturating fail counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to run a march test.
REQ-006 SHALL have port bg_sel, input, 1, background select: 0 = all-zeros, 1 = checkerboard 72'h55...55.
REQ-007 SHALL have ports rd0_enb, rd0_adr, output, 1 and 6, read port 0 command to the 2r1w 64x72 array.
REQ-008 SHALL have ports rd1_enb, rd1_adr, output, 1 and 6, read port 1 command.
REQ-009 SHALL have ports rd0_dat, rd1_dat, input, 72 each, array read data.
REQ-010 SHALL have ports wr0_enb, wr0_adr, wr0_dat, output, 1, 6 and 72, write port command.
REQ-011 SHALL have ports busy, done, fail, output, 1 each; fail_adr, output, 6; fail_cnt, output, FAIL_CW.

Function
REQ-012 SHALL run March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0). "0" = background D, "1" = ~D.
REQ-013 SHALL use states IDLE -> RUN -> DRAIN -> DONE; start in IDLE or DONE -> RUN, element M0, address 0.
REQ-014 SHALL issue one array operation per cycle in RUN: w-only/r-only elements take 1 cycle per address; r,w elements take read cycle then write cycle at the same address.
REQ-015 SHALL step address 0..63 for up elements and 63..0 for down elements; at terminal address advance to next element without idle cycle.
REQ-016 SHALL take exactly 640 RUN cycles, then RD_LAT DRAIN cycles, then enter DONE.
REQ-017 SHALL drive rd1_enb low and rd1_adr = 0 at all times when the dual-read feature is compiled out.
REQ-018 SHALL pipeline expected data and a valid flag RD_LAT cycles, comparing rd0_dat only when the delayed valid is 1.
REQ-019 SHALL on mismatch set fail (sticky), capture fail_adr only on the first mismatch of the run, and increment fail_cnt saturating at all-ones.
REQ-020 SHALL assert busy in RUN and DRAIN, done only in DONE (held until next start).
REQ-021 SHALL ignore start while busy; start in DONE clears done, fail, fail_adr, fail_cnt in the same edge that enters RUN.
REQ-022 SHALL hold all enables low in IDLE, DRAIN and DONE.

Reset
REQ-023 SHALL on reset low asynchronously force IDLE, all enables 0, all addresses and wr0_dat 0, busy/done/fail 0, fail_adr 0, fail_cnt 0, and clear the compare pipeline.
REQ-024 SHALL abort a run on mid-operation reset, with no further array commands until a new start after release.

Configuration
REQ-025 SHALL, with RA_MARCH_DUAL_RD_EN defined, issue each read on both ports (rd1_adr = rd0_adr) and compare rd1_dat alongside rd0_dat; a mismatch on either port counts once per cycle.
REQ-026 SHALL, without RA_MARCH_DUAL_RD_EN, contain no port-1 compare logic and ignore rd1_dat.

Verification
REQ-027 SHALL cover: fault-free array model, bg_sel=0, start pulse -> busy 640+RD_LAT cycles, done=1, fail=0, fail_cnt=0.
REQ-028 SHALL cover: bit 0 of word 6'h12 stuck-at-1, bg_sel=0 -> fail=1, fail_adr=6'h12, fail_cnt=3 (reads in M1, M3, M5).
REQ-029 SHALL cover: bg_sel=1 -> M0 writes 72'h55...55, M1 writes 72'hAA...AA; first M3 read address is 6'h3F.
REQ-030 SHALL cover: start asserted during RUN -> no restart, cycle count unchanged; start in DONE -> status cleared, new run.
REQ-031 SHALL cover: reset low at RUN cycle 300 -> all outputs at reset values immediately, no commands until next start.
REQ-032 SHALL cover: RA_MARCH_DUAL_RD_EN defined, fault only on port-1 read of 6'h05 -> fail=1, fail_adr=6'h05, rd1_adr tracks rd0_adr.

Source files
------------

// File: rtl/ra_march_sdr.sv
// ra_march_sdr: March C- self-test sequencer and read-data checker for a 2r1w 64x72 array.
// Define RA_MARCH_DUAL_RD_EN to issue every read on both read ports and check both.
module ra_march_sdr #(
    parameter int RD_LAT  = 1,
    parameter int FAIL_CW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               bg_sel,
    output logic               rd0_enb,
    output logic [5:0]         rd0_adr,
    output logic               rd1_enb,
    output logic [5:0]         rd1_adr,
    input  logic [71:0]        rd0_dat,
    input  logic [71:0]        rd1_dat,
    output logic               wr0_enb,
    output logic [5:0]         wr0_adr,
    output logic [71:0]        wr0_dat,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [5:0]         fail_adr,
    output logic [FAIL_CW-1:0] fail_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t      state;
    logic [2:0]  elem, n_elem;
    logic [5:0]  adr, n_adr;
    logic        ph, n_ph, last, term, step, go, n_rd, n_inv, bg_r, mm;
    logic [71:0] bg, n_dat;
    logic [1:0]  drain;
    logic [71:0] exp_p [RD_LAT+1];
    logic [5:0]  adr_p [RD_LAT+1];
    logic        vld_p [RD_LAT+1];

    function automatic logic is_dn(input logic [2:0] e);
        return e == 3'd3 || e == 3'd4;
    endfunction

    function automatic logic is_rw(input logic [2:0] e);
        return e != 3'd0 && e != 3'd5;
    endfunction

    assign go = start && (state == IDLE || state == DONE);
    assign bg = (go ? bg_sel : bg_r) ? {36{2'b01}} : 72'd0;

    // Next array operation; elements 1..4 spend a read phase then a write phase per address.
    always_comb begin
        last   = elem == 3'd5 && adr == 6'd63;
        term   = adr == (is_dn(elem) ? 6'd0 : 6'd63);
        step   = is_rw(elem) && !ph;
        n_elem = go ? 3'd0 : (!step && term) ? elem + 3'd1 : elem;
        n_ph   = !go && step;
        n_adr  = go ? 6'd0 : step ? adr : term ? (is_dn(n_elem) ? 6'd63 : 6'd0) :
                 is_dn(elem) ? adr - 6'd1 : adr + 6'd1;
        n_rd   = n_elem == 3'd5 || (is_rw(n_elem) && !n_ph);
        n_inv  = n_rd ? (n_elem == 3'd2 || n_elem == 3'd4) : n_elem[0];
        n_dat  = n_inv ? ~bg : bg;
    end

`ifdef RA_MARCH_DUAL_RD_EN
    assign rd1_enb = rd0_enb;
    assign rd1_adr = rd0_adr;
    assign mm      = vld_p[RD_LAT] && (rd0_dat != exp_p[RD_LAT] || rd1_dat != exp_p[RD_LAT]);
`else
    logic unused_rd1;
    assign rd1_enb    = 1'b0;
    assign rd1_adr    = 6'd0;
    assign unused_rd1 = ^rd1_dat;
    assign mm         = vld_p[RD_LAT] && rd0_dat != exp_p[RD_LAT];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            elem     <= 3'd0;
            adr      <= 6'd0;
            ph       <= 1'b0;
            bg_r     <= 1'b0;
            drain    <= 2'd0;
            rd0_enb  <= 1'b0;
            rd0_adr  <= 6'd0;
            wr0_enb  <= 1'b0;
            wr0_adr  <= 6'd0;
            wr0_dat  <= 72'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            fail_adr <= 6'd0;
            fail_cnt <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
                exp_p[i] <= 72'd0;
                adr_p[i] <= 6'd0;
            end
        end else begin
            rd0_enb  <= 1'b0;
            wr0_enb  <= 1'b0;
            vld_p[0] <= 1'b0;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                exp_p[i] <= exp_p[i-1];
                adr_p[i] <= adr_p[i-1];
            end
            if (mm) begin
                fail <= 1'b1;
                if (!fail) fail_adr <= adr_p[RD_LAT];
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
            if (go || (state == RUN && !last)) begin
                state    <= RUN;
                busy     <= 1'b1;
                done     <= 1'b0;
                elem     <= n_elem;
                adr      <= n_adr;
                ph       <= n_ph;
                rd0_enb  <= n_rd;
                wr0_enb  <= !n_rd;
                rd0_adr  <= n_adr;
                wr0_adr  <= n_adr;
                wr0_dat  <= n_dat;
                vld_p[0] <= n_rd;
                exp_p[0] <= n_dat;
                adr_p[0] <= n_adr;
            end
            if (go) begin
                bg_r     <= bg_sel;
                fail     <= 1'b0;
                fail_adr <= 6'd0;
                fail_cnt <= '0;
            end
            if (state == RUN && last) begin
                state <= DRAIN;
                drain <= 2'(RD_LAT - 1);
            end
            if (state == DRAIN) begin
                drain <= drain - 2'd1;
                if (drain == 2'd0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule
